// File: rtl/xnor_chk_pkg.sv
// xnor_chk_pkg
//   Shared definitions for the XNOR equivalence checker.
//   - state_t and ST_* : FSM state encoding
//   - NUM_IN_DEFAULT / NUM_VEC : default stimulus width and the number of
//     vectors in one full sweep at that width
//   - num_vec()  : vectors in one sweep for a given stimulus width
//   - sweep_w()  : width of the sweep counter for a given REPEAT. This is
//     clog2(REPEAT), but never less than 1 bit, so REPEAT=1 still gets a
//     real register.
package xnor_chk_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int NUM_IN_DEFAULT = 3;
  localparam int NUM_VEC        = 1 << NUM_IN_DEFAULT;

  function automatic int num_vec(input int num_in);
    return 1 << num_in;
  endfunction

  function automatic int sweep_w(input int rep);
    int w;
    w = 1;
    while ((1 << w) < rep) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/xnor_equiv_checker_if.sv
// xnor_equiv_checker_if
//   Groups the checker's start/done handshake with the stimulus/result bus
//   of the compare block.
//   Parameters: NUM_IN (stimulus width), CNT_W (mismatch counter width).
//   Signals:
//     start         host -> checker   request a run
//     busy          checker -> host   run in progress
//     done          checker -> host   result valid, held
//     pass          checker -> host   done with zero mismatches
//     mismatch_cnt  checker -> host   saturating mismatch count
//     stim          checker -> compare block   {a,b,c} vector
//     ref_in        compare block -> checker   direct 3-input gate result
//     imp_in        compare block -> checker   cascaded 2-input gate result
//     first_fail_vec/first_fail_vld  checker -> host; present only when
//       XNOR_CHK_FIRST_FAIL_EN is defined.
//   Modports: slave = the checker, master = host plus compare block.
interface xnor_equiv_checker_if #(
  parameter int NUM_IN = 3,
  parameter int CNT_W  = 8
);

  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic [NUM_IN-1:0] stim;
  logic              ref_in;
  logic              imp_in;
`ifdef XNOR_CHK_FIRST_FAIL_EN
  logic [NUM_IN-1:0] first_fail_vec;
  logic              first_fail_vld;
`endif

  modport slave (
    input  start, ref_in, imp_in,
`ifdef XNOR_CHK_FIRST_FAIL_EN
    output first_fail_vec, first_fail_vld,
`endif
    output stim, busy, done, pass, mismatch_cnt
  );

  modport master (
    output start, ref_in, imp_in,
`ifdef XNOR_CHK_FIRST_FAIL_EN
    input  first_fail_vec, first_fail_vld,
`endif
    input  stim, busy, done, pass, mismatch_cnt
  );

endinterface

// File: rtl/xnor_chk_stim_gen.sv
// xnor_chk_stim_gen
//   Vector counter plus sweep counter used to drive an exhaustive sweep.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     clr         restart at vector 0, sweep 0 (wins over en)
//     en          advance one vector; wrapping the vector bumps the sweep
//     vec         current vector (registered)
//     last        vec is all-ones and this is the final sweep
module xnor_chk_stim_gen
  import xnor_chk_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int REPEAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic [NUM_IN-1:0] vec,
  output logic              last
);

  localparam int                SW         = sweep_w(REPEAT);
  localparam logic [NUM_IN-1:0] VEC_LAST   = NUM_IN'(num_vec(NUM_IN) - 1);
  localparam logic [SW-1:0]     SWEEP_LAST = SW'(REPEAT - 1);

  logic [NUM_IN-1:0] vec_q, vec_d;
  logic [SW-1:0]     sweep_q, sweep_d;

  always_comb begin
    vec_d   = vec_q;
    sweep_d = sweep_q;
    if (clr) begin
      vec_d   = '0;
      sweep_d = '0;
    end else if (en) begin
      vec_d = vec_q + 1'b1;
      if (vec_q == VEC_LAST) sweep_d = sweep_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_q   <= '0;
      sweep_q <= '0;
    end else begin
      vec_q   <= vec_d;
      sweep_q <= sweep_d;
    end
  end

  assign vec  = vec_q;
  assign last = (vec_q == VEC_LAST) && (sweep_q == SWEEP_LAST);

endmodule

// File: rtl/xnor_equiv_checker.sv
// xnor_equiv_checker
//   Self-checking sequencer for the XNOR equivalence stage. It sweeps every
//   stim vector REPEAT times, compares the direct and cascaded gate results
//   and reports a saturating mismatch count through a start/done handshake.
//   Parameters: NUM_IN (stim width), REPEAT (sweeps per run, >= 1),
//               CNT_W (mismatch counter width).
//   Ports: clk, rst_n (synchronous active-low), bus (xnor_equiv_checker_if.slave)
//   Optional: XNOR_CHK_FIRST_FAIL_EN adds first_fail_vec/first_fail_vld,
//             which capture the stim of the first mismatch in a run.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start after reset
//   RUN   | one vector per cycle: sample ref^imp, fold previous sample
//   DRAIN | fold the last sample registered in RUN
//   DONE  | result held; start begins a new run
module xnor_equiv_checker
  import xnor_chk_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEFAULT,
  parameter int REPEAT = 1,
  parameter int CNT_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  xnor_equiv_checker_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic              sample_q, sample_d;
  logic              sample_vld_q, sample_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_fold;
  logic              cur_mis;
  logic              stim_clr;
  logic              stim_en;
  logic [NUM_IN-1:0] stim_vec;
  logic              stim_last;
`ifdef XNOR_CHK_FIRST_FAIL_EN
  logic [NUM_IN-1:0] ff_vec_q, ff_vec_d;
  logic              ff_vld_q, ff_vld_d;
`else
  // No first-fail capture registers in this build.
`endif

  xnor_chk_stim_gen #(
    .NUM_IN (NUM_IN),
    .REPEAT (REPEAT)
  ) u_stim_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (stim_clr),
    .en    (stim_en),
    .vec   (stim_vec),
    .last  (stim_last)
  );

  assign cur_mis = bus.ref_in ^ bus.imp_in;

  // Sample is one cycle behind stim, so the count lags by one fold; DRAIN
  // exists to absorb the sample of the final vector.
  assign cnt_fold = (sample_vld_q && sample_q && (cnt_q != CNT_MAX)) ?
                    cnt_q + 1'b1 : cnt_q;

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    sample_vld_d = sample_vld_q;
    cnt_d        = cnt_q;
    stim_clr     = 1'b0;
    stim_en      = 1'b0;
`ifdef XNOR_CHK_FIRST_FAIL_EN
    ff_vec_d     = ff_vec_q;
    ff_vld_d     = ff_vld_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_RUN;
          stim_clr     = 1'b1;
          cnt_d        = '0;
          sample_d     = 1'b0;
          sample_vld_d = 1'b0;
`ifdef XNOR_CHK_FIRST_FAIL_EN
          ff_vec_d     = '0;
          ff_vld_d     = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        sample_d     = cur_mis;
        sample_vld_d = 1'b1;
        cnt_d        = cnt_fold;
        // stim is not advanced on the final vector, so it holds the last
        // driven value through DRAIN and DONE.
        if (stim_last) state_d = ST_DRAIN;
        else           stim_en = 1'b1;
`ifdef XNOR_CHK_FIRST_FAIL_EN
        if (cur_mis && !ff_vld_q) begin
          ff_vec_d = stim_vec;
          ff_vld_d = 1'b1;
        end
`endif
      end
      ST_DRAIN: begin
        cnt_d        = cnt_fold;
        sample_vld_d = 1'b0;
        state_d      = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sample_q     <= 1'b0;
      sample_vld_q <= 1'b0;
      cnt_q        <= '0;
`ifdef XNOR_CHK_FIRST_FAIL_EN
      ff_vec_q     <= '0;
      ff_vld_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      cnt_q        <= cnt_d;
`ifdef XNOR_CHK_FIRST_FAIL_EN
      ff_vec_q     <= ff_vec_d;
      ff_vld_q     <= ff_vld_d;
`endif
    end
  end

  assign bus.stim         = stim_vec;
  assign bus.busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.pass         = (state_q == ST_DONE) && (cnt_q == '0);
  assign bus.mismatch_cnt = cnt_q;
`ifdef XNOR_CHK_FIRST_FAIL_EN
  assign bus.first_fail_vec = ff_vec_q;
  assign bus.first_fail_vld = ff_vld_q;
`endif

endmodule
